dpram_b_loader: RTL

// - Port-B initiator for the shared dual-port RAM: drains the HPS ioctl download stream into RAM (cart/BIOS image load).
// - A 4-entry FIFO absorbs ioctl bursts; a port-B sequencer issues one write per entry and can read back to verify.
// - Sits between the ioctl download interface and dpram port B. The CPU keeps port A.

---
 rtl/dpram_b_loader_pkg.sv | 11 +
 rtl/dpram_b_loader_sync_fifo.sv | 36 +++
 rtl/dpram_b_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/dpram_b_loader_pkg.sv
// dpram_b_loader_pkg: sequencer states, watchdog length and FIFO entry layout for dpram_b_loader
package dpram_b_loader_pkg;
  localparam int ACK_TIMEOUT = 4;
  localparam int ENTRY_ADDR_W = 14;
  localparam int ENTRY_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, FINISH} loader_state_t;
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/dpram_b_loader_sync_fifo.sv
// sync_fifo: small first-word-fall-through FIFO with full/empty flags and same-cycle push/pop
module sync_fifo #(
  parameter int W = 22,
  parameter int LG2 = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**LG2];
  logic [LG2-1:0] wp, rp;
  logic [LG2:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (LG2+1)'(2**LG2);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (LG2+1)'(do_push) - (LG2+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/dpram_b_loader.sv
// dpram_b_loader: drains the ioctl download into dpram port B through a FIFO; DPRAM_B_LOADER_VERIFY_EN adds readback verify
module dpram_b_loader
  import dpram_b_loader_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int FIFO_LG2 = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              ram_cs_b,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_ad_b,
  output logic [DATA_W-1:0] ram_d_b,
  input  logic              b_ack,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow,
  output logic              verify_err
);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0] BC_MAX = {1'b1, {ADDR_W{1'b0}}};
  loader_state_t state, state_n;
  logic dl_q, pend_fall, clr_pend, full, empty, push, pop, in_range, rise, clr;
  logic [EW-1:0] fifo_q;
  logic [ADDR_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_d;
  assign in_range = ioctl_addr[26:ADDR_W] == '0;
  assign push = ioctl_wr && in_range && !full;
  assign pop = state == IDLE && !empty;
  assign rise = ioctl_download && !dl_q;
  // a restart seen during FINISH clears the counters only once the pulse is out
  assign clr = (rise || clr_pend) && state != FINISH;
  assign ioctl_wait = full;
  assign busy = ioctl_download || !empty || state != IDLE;
  assign ram_ad_b = hold_a;
  assign ram_d_b = hold_d;
  sync_fifo #(.W(EW), .LG2(FIFO_LG2)) u_fifo (
    .clk(clk_sys),
    .reset_n(reset_n),
    .push(push),
    .din({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .pop(pop),
    .dout(fifo_q),
    .full(full),
    .empty(empty)
  );
`ifdef DPRAM_B_LOADER_VERIFY_EN
  localparam int WD_W = $clog2(ACK_TIMEOUT);
  logic [WD_W-1:0] wd;
  logic to;
  assign to = wd == WD_W'(ACK_TIMEOUT - 1);
`endif
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = !empty ? WRITE : pend_fall ? FINISH : IDLE;
`ifdef DPRAM_B_LOADER_VERIFY_EN
      WRITE: state_n = RD_REQ;
      RD_REQ: state_n = RD_WAIT;
      RD_WAIT: state_n = (b_ack || to) ? IDLE : RD_WAIT;
`else
      WRITE: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      dl_q <= 1'b0;
      pend_fall <= 1'b0;
      clr_pend <= 1'b0;
      ram_we_b <= 1'b0;
      ram_cs_b <= 1'b0;
      load_done <= 1'b0;
      hold_a <= '0;
      hold_d <= '0;
      byte_count <= '0;
      overflow <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      pend_fall <= (pend_fall || dl_q && !ioctl_download) && state_n != FINISH;
      clr_pend <= (rise || clr_pend) && state == FINISH;
      ram_we_b <= state_n == WRITE;
      ram_cs_b <= state_n == RD_REQ;
      load_done <= state_n == FINISH;
      {hold_a, hold_d} <= pop ? fifo_q : {hold_a, hold_d};
      byte_count <= clr ? '0 : (state == WRITE && byte_count != BC_MAX) ? byte_count + 1'b1 : byte_count;
      overflow <= overflow && !clr || ioctl_wr && (!in_range || full);
    end
`ifdef DPRAM_B_LOADER_VERIFY_EN
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wd <= '0;
      verify_err <= 1'b0;
    end else begin
      wd <= state == RD_WAIT ? wd + 1'b1 : '0;
      verify_err <= verify_err && !clr || state == RD_WAIT && (b_ack ? ram_q_b != hold_d : to);
    end
`else
  logic unused;
  assign unused = &{1'b0, b_ack, ram_q_b};
  assign verify_err = 1'b0;
`endif
endmodule
